// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Phase controller for a two-way junction. It drives the enable of an
// external BCD countdown counter (00 -> 20 -> 19 ... 01 -> 00 -> 20 while
// enabled, 00 while disabled) and watches the count to sequence the
// north-south and east-west heads through green, yellow and all-red.
// A pedestrian request stretches the next all-red into a walk interval.
// A non-BCD count while the counter is enabled latches a sticky fault and
// the heads fall back to flashing yellow until reset.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   run      in   1 = sequence lights, 0 = go to OFF (both red)
//   cnt      in   8-bit BCD count from the countdown counter
//   ped_req  in   pedestrian request, level or pulse
//   cnt_en   out  enable to the countdown counter
//   ns_light out  NS head, one-hot {red,yellow,green}
//   ew_light out  EW head, one-hot {red,yellow,green}
//   walk     out  pedestrian walk indication
//   fault    out  sticky BCD fault flag
module traffic_light_ctrl #(
  parameter logic [7:0] YELLOW_AT  = 8'h05,
  parameter int         ALLRED_CYC = 2,
  parameter int         WALK_CYC   = 4,
  parameter int         FLASH_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] cnt,
  input  logic       ped_req,
  output logic       cnt_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       fault
);

  // One timer serves both the all-red clearance and the fault flash.
  localparam int TMAX = ((ALLRED_CYC + WALK_CYC) > FLASH_CYC) ? (ALLRED_CYC + WALK_CYC) : FLASH_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] HEAD_RED  = 3'b100;
  localparam logic [2:0] HEAD_YEL  = 3'b010;
  localparam logic [2:0] HEAD_GRN  = 3'b001;
  localparam logic [2:0] HEAD_DARK = 3'b000;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ALLRED = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic          next_dir_r, dir_s;      // 0 = NS gets the next green, 1 = EW
  logic          armed_r, armed_s;
  logic          ped_pend_r, ped_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          flash_off_r, flash_s;   // 0 = yellow half of the flash
  logic          fault_s;
  logic          cnt_en_s;
  logic [2:0]    ns_s, ew_s;
  logic          walk_s;
  logic [TW-1:0] allred_last_s;

  // A count digit above 9 means the counter or its wiring is broken.
  function automatic logic bcd_bad(input logic [7:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
  endfunction

  // Last timer value of the current all-red, stretched when a walk is owed.
  always_comb begin
    if (ped_pend_r) begin
      allred_last_s = TW'(ALLRED_CYC + WALK_CYC - 1);
    end else begin
      allred_last_s = TW'(ALLRED_CYC - 1);
    end
  end

  // Next-state logic: fault detect beats run=0, which beats normal sequencing.
  always_comb begin
    state_s = state_r;
    dir_s   = next_dir_r;
    armed_s = armed_r;
    ped_s   = ped_pend_r;
    timer_s = timer_r;
    flash_s = flash_off_r;
    fault_s = fault;

    if (cnt_en && bcd_bad(cnt)) begin
      state_s = S_FAULT;
      fault_s = 1'b1;
      timer_s = '0;
      flash_s = 1'b0;
    end else if (!run && (state_r != S_FAULT)) begin
      state_s = S_OFF;
      armed_s = 1'b0;
      ped_s   = 1'b0;
      timer_s = '0;
    end else begin
      case (state_r)
        S_OFF: begin
          // Reaching here means run=1: always restart through a full all-red.
          state_s = S_ALLRED;
          armed_s = 1'b0;
          timer_s = '0;
        end
        S_ALLRED: begin
          armed_s = 1'b0;
          if (timer_r == allred_last_s) begin
            state_s = S_GREEN;
            ped_s   = 1'b0;
            timer_s = '0;
          end else begin
            state_s = S_ALLRED;
            timer_s = timer_r + TW'(1);
          end
        end
        S_GREEN: begin
          // The count is a stale 00 on green entry; arm only once it reloads.
          if (cnt != 8'h00) begin
            armed_s = 1'b1;
          end else begin
            armed_s = armed_r;
          end
          if (ped_req) begin
            ped_s = 1'b1;
          end else begin
            ped_s = ped_pend_r;
          end
          if ((cnt != 8'h00) && (cnt <= YELLOW_AT)) begin
            state_s = S_YELLOW;
          end else begin
            state_s = S_GREEN;
          end
        end
        S_YELLOW: begin
          if (cnt != 8'h00) begin
            armed_s = 1'b1;
          end else begin
            armed_s = armed_r;
          end
          if (ped_req) begin
            ped_s = 1'b1;
          end else begin
            ped_s = ped_pend_r;
          end
          if (armed_r && (cnt == 8'h00)) begin
            state_s = S_ALLRED;
            dir_s   = ~next_dir_r;
            timer_s = '0;
          end else begin
            state_s = S_YELLOW;
          end
        end
        S_FAULT: begin
          if (timer_r == TW'(FLASH_CYC - 1)) begin
            timer_s = '0;
            flash_s = ~flash_off_r;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        default: begin
          // Corrupted state encoding: fall back to the safe flashing mode.
          state_s = S_FAULT;
          fault_s = 1'b1;
          timer_s = '0;
          flash_s = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track state_r.
  always_comb begin
    cnt_en_s = 1'b0;
    ns_s     = HEAD_RED;
    ew_s     = HEAD_RED;
    walk_s   = 1'b0;
    case (state_s)
      S_OFF: begin
        cnt_en_s = 1'b0;
      end
      S_ALLRED: begin
        walk_s = ped_s;
      end
      S_GREEN: begin
        cnt_en_s = 1'b1;
        if (dir_s) begin
          ew_s = HEAD_GRN;
        end else begin
          ns_s = HEAD_GRN;
        end
      end
      S_YELLOW: begin
        cnt_en_s = 1'b1;
        if (dir_s) begin
          ew_s = HEAD_YEL;
        end else begin
          ns_s = HEAD_YEL;
        end
      end
      S_FAULT: begin
        if (flash_s) begin
          ns_s = HEAD_DARK;
          ew_s = HEAD_DARK;
        end else begin
          ns_s = HEAD_YEL;
          ew_s = HEAD_YEL;
        end
      end
      default: begin
        cnt_en_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_OFF;
      next_dir_r  <= 1'b0;
      armed_r     <= 1'b0;
      ped_pend_r  <= 1'b0;
      timer_r     <= '0;
      flash_off_r <= 1'b0;
      fault       <= 1'b0;
      cnt_en      <= 1'b0;
      ns_light    <= HEAD_RED;
      ew_light    <= HEAD_RED;
      walk        <= 1'b0;
    end else begin
      state_r     <= state_s;
      next_dir_r  <= dir_s;
      armed_r     <= armed_s;
      ped_pend_r  <= ped_s;
      timer_r     <= timer_s;
      flash_off_r <= flash_s;
      fault       <= fault_s;
      cnt_en      <= cnt_en_s;
      ns_light    <= ns_s;
      ew_light    <= ew_s;
      walk        <= walk_s;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl. A behavioural BCD countdown counter
// closes the loop around the controller. The stimulus process pushes
// hand-computed per-cycle expectations into a queue; an independent
// monitor pops and compares them on the falling edge.
module tb_traffic_light_ctrl;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] cnt;
  logic       ped_req;
  logic       cnt_en;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       fault;

  logic [7:0] cnt_m;
  logic       inj;
  logic [7:0] inj_val;
  int         cyc;

  typedef struct {
    string      tag;
    int         c;
    logic       en;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       flt;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_pass;
  int   n_to;

  traffic_light_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cnt      (cnt),
    .ped_req  (ped_req),
    .cnt_en   (cnt_en),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cnt = inj ? inj_val : cnt_m;

  // Behavioural countdown counter: 00 -> 20 -> 19 ... 01 -> 00, cleared when disabled.
  always @(posedge clk) begin
    if (rst || !cnt_en) begin
      cnt_m <= 8'h00;
    end else if (cnt_m == 8'h00) begin
      cnt_m <= 8'h20;
    end else if (cnt_m[3:0] == 4'd0) begin
      cnt_m <= {cnt_m[7:4] - 4'd1, 4'd9};
    end else begin
      cnt_m <= cnt_m - 8'd1;
    end
  end

  // Cycle index: 0 is the first cycle after the last reset edge.
  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
    end
  end

  task automatic exp_rng(input string tag, input int a, input int b, input logic en,
                         input logic [2:0] ns, input logic [2:0] ew,
                         input logic wk, input logic flt);
    exp_t e;
    for (int i = a; i <= b; i++) begin
      e.tag = tag; e.c = i; e.en = en; e.ns = ns; e.ew = ew; e.wk = wk; e.flt = flt;
      q.push_back(e);
    end
  endtask

  // Advance to #1 after the edge that starts cycle k (bounded).
  task automatic go_to(input int k);
    int n;
    n = 0;
    while ((cyc != k) && (n < 500)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != k) begin
      n_to++;
      $display("FAIL go_to: reached cycle %0d, required %0d", cyc, k);
    end
  endtask

  task automatic do_reset(input logic r);
    rst = 1'b1; run = 1'b0; ped_req = 1'b0; inj = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = r;
  endtask

  // Monitor: compare DUT outputs against the queued expectation for this cycle.
  initial begin
    exp_t e;
    n_checks = 0;
    n_pass   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while ((q.size() > 0) && (q[0].c < cyc)) begin
          e = q.pop_front();
          n_checks++;
          $display("FAIL %s c%0d: expectation never compared (now c%0d)", e.tag, e.c, cyc);
        end
        if ((q.size() > 0) && (q[0].c == cyc)) begin
          e = q.pop_front();
          n_checks++;
          if ((cnt_en === e.en) && (ns_light === e.ns) && (ew_light === e.ew) &&
              (walk === e.wk) && (fault === e.flt)) begin
            n_pass++;
          end else begin
            $display("FAIL %s c%0d: got en=%b ns=%b ew=%b walk=%b fault=%b, required en=%b ns=%b ew=%b walk=%b fault=%b",
                     e.tag, e.c, cnt_en, ns_light, ew_light, walk, fault,
                     e.en, e.ns, e.ew, e.wk, e.flt);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios with hand-derived cycle-by-cycle outcomes.
  initial begin
    n_to = 0;
    rst = 1'b1; run = 1'b0; ped_req = 1'b0; inj = 1'b0; inj_val = 8'h00;

    // Full NS -> EW -> NS rotation with default timing.
    do_reset(1'b1);
    exp_rng("a_off",    0,  0, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("a_ar1",    1,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("a_nsg",    3, 19, 1'b1, GRN, RED, 1'b0, 1'b0);
    exp_rng("a_nsy",   20, 24, 1'b1, YEL, RED, 1'b0, 1'b0);
    exp_rng("a_ar2",   25, 26, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("a_ewg",   27, 43, 1'b1, RED, GRN, 1'b0, 1'b0);
    exp_rng("a_ewy",   44, 48, 1'b1, RED, YEL, 1'b0, 1'b0);
    exp_rng("a_ar3",   49, 50, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("a_nsg2",  51, 55, 1'b1, GRN, RED, 1'b0, 1'b0);
    go_to(56);

    // Pedestrian pulse during NS green stretches the next all-red.
    do_reset(1'b1);
    exp_rng("b_off",    0,  0, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("b_ar1",    1,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("b_nsg",    3, 19, 1'b1, GRN, RED, 1'b0, 1'b0);
    exp_rng("b_nsy",   20, 24, 1'b1, YEL, RED, 1'b0, 1'b0);
    exp_rng("b_walk",  25, 30, 1'b0, RED, RED, 1'b1, 1'b0);
    exp_rng("b_ewg",   31, 47, 1'b1, RED, GRN, 1'b0, 1'b0);
    exp_rng("b_ewy",   48, 52, 1'b1, RED, YEL, 1'b0, 1'b0);
    exp_rng("b_ar3",   53, 54, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("b_nsg2",  55, 55, 1'b1, GRN, RED, 1'b0, 1'b0);
    go_to(10); ped_req = 1'b1;
    go_to(11); ped_req = 1'b0;
    go_to(56);

    // run dropped during NS yellow at cnt=03, then restored.
    do_reset(1'b1);
    exp_rng("c_off",    0,  0, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("c_ar1",    1,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("c_nsg",    3, 19, 1'b1, GRN, RED, 1'b0, 1'b0);
    exp_rng("c_nsy",   20, 21, 1'b1, YEL, RED, 1'b0, 1'b0);
    exp_rng("c_off2",  22, 23, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("c_ar2",   24, 25, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("c_nsg2",  26, 42, 1'b1, GRN, RED, 1'b0, 1'b0);
    exp_rng("c_nsy2",  43, 43, 1'b1, YEL, RED, 1'b0, 1'b0);
    go_to(21); run = 1'b0;
    go_to(23); run = 1'b1;
    go_to(44);

    // Non-BCD count during green: sticky fault and flashing yellow.
    do_reset(1'b1);
    exp_rng("d_off",    0,  0, 1'b0, RED,  RED,  1'b0, 1'b0);
    exp_rng("d_ar1",    1,  2, 1'b0, RED,  RED,  1'b0, 1'b0);
    exp_rng("d_nsg",    3,  5, 1'b1, GRN,  RED,  1'b0, 1'b0);
    exp_rng("d_flyel",  6, 13, 1'b0, YEL,  YEL,  1'b0, 1'b1);
    exp_rng("d_fldrk", 14, 21, 1'b0, DARK, DARK, 1'b0, 1'b1);
    exp_rng("d_flyel2",22, 29, 1'b0, YEL,  YEL,  1'b0, 1'b1);
    go_to(5);  inj_val = 8'h1A; inj = 1'b1;
    go_to(6);  inj = 1'b0;
    go_to(10); run = 1'b0;
    go_to(15); run = 1'b1;
    go_to(20); run = 1'b0;
    go_to(30);
    do_reset(1'b0);
    exp_rng("d_rstoff", 0,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    go_to(3);

    // Reset in the middle of a walk-extended all-red.
    do_reset(1'b1);
    exp_rng("e_off",    0,  0, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("e_ar1",    1,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("e_nsg",    3, 19, 1'b1, GRN, RED, 1'b0, 1'b0);
    exp_rng("e_nsy",   20, 24, 1'b1, YEL, RED, 1'b0, 1'b0);
    exp_rng("e_walk",  25, 26, 1'b0, RED, RED, 1'b1, 1'b0);
    go_to(10); ped_req = 1'b1;
    go_to(11); ped_req = 1'b0;
    go_to(27);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rng("e_off2",   0,  0, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("e_ar2",    1,  2, 1'b0, RED, RED, 1'b0, 1'b0);
    exp_rng("e_nsg2",   3,  4, 1'b1, GRN, RED, 1'b0, 1'b0);
    go_to(5);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL leftover: %0d expectations not compared, required 0", q.size());
      n_to += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + n_to);
    $finish;
  end

  // Absolute time limit in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Phase controller that consumes the BCD countdown (0 -> 20 -> 19 ... 01 -> 00 -> 20 while enabled, forced to 00 when disabled) from the light countdown counter, and drives that counter's enable. Sequences north-south and east-west signal heads through green, yellow and all-red phases. Extends all-red for a pedestrian walk interval on request. Latches a fault on non-BCD count input and falls back to flashing yellow.

Parameters:
YELLOW_AT, 8'h05, BCD count threshold; green ends when count <= this value (nonzero)
ALLRED_CYC, 2, all-red clearance length in cycles (>=1)
WALK_CYC, 4, extra all-red cycles added when a walk is served (>=0)
FLASH_CYC, 8, half-period of the fault flash in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = sequence lights; 0 = go to OFF
cnt  in  8  BCD count from countdown counter ([7:4] tens, [3:0] units)
ped_req  in  1  pedestrian request, level or pulse, sampled every cycle
cnt_en  out  1  enable to countdown counter
ns_light  out  3  NS head, one-hot {red,yellow,green}
ew_light  out  3  EW head, one-hot {red,yellow,green}
walk  out  1  pedestrian walk indication
fault  out  1  sticky BCD fault flag

Behaviour:
- Interface fixed: single clock clk; rst is synchronous and active-high; all state updates on the rising edge of clk only.
- Outputs are a pure decode of registered state, so they change the cycle after a condition is seen. No combinational path from inputs to outputs.
- Reset values: state OFF, next_dir=NS, armed=0, ped_pend=0, fault=0, timers=0, cnt_en=0, ns_light=ew_light=3'b100, walk=0.
- States:
  - OFF: cnt_en=0, both red, walk=0. If run=1, go to ALLRED with the timer cleared.
  - ALLRED: cnt_en=0, both red, walk=ped_pend. Timer counts from 0. Exit at timer == ALLRED_CYC-1, or ALLRED_CYC+WALK_CYC-1 if ped_pend. Exit goes to GREEN for next_dir and clears ped_pend.
  - GREEN: cnt_en=1. Active head green, other head red. Go to YELLOW when cnt != 0 and cnt <= YELLOW_AT. Compare as unsigned 8-bit, which is valid ordering for legal BCD.
  - YELLOW: cnt_en=1. Active head yellow, other head red. Go to ALLRED when armed=1 and cnt == 0. On exit, toggle next_dir and clear the timer.
  - FAULT: cnt_en=0, walk=0. Both heads are 3'b010 and 3'b000 alternately, toggling every FLASH_CYC cycles and starting at yellow. Only rst exits.
- armed: set in GREEN/YELLOW when cnt != 0; cleared in OFF/ALLRED. It guards against acting on the stale 00 present on green entry.
- ped_pend: set when ped_req=1 in GREEN or YELLOW. It is ignored in OFF, ALLRED and FAULT, so a request during all-red waits for the following all-red.
- Fault: when cnt_en=1 and cnt[3:0] > 9 or cnt[7:4] > 9, set fault and enter FAULT next cycle. This overrides every other transition.
- Priority each cycle: rst > fault detect > run=0 (any state except FAULT goes to OFF, clears armed, ped_pend, timers; next_dir is kept) > normal transitions.
- run toggled mid-phase:
  - Re-entry from OFF always passes through a full ALLRED.
  - The counter sees cnt_en=0, so it clears.

Test Plan:
- rst, then run=1 at cycle 0 with a behavioural counter model, defaults: OFF c0, ALLRED c1-c2, NS green c3-c19 (cnt 00,20..05), NS yellow c20-c24 (cnt 04..00), ALLRED c25-c26, EW green c27; cnt_en low exactly in OFF/ALLRED.
- Full cycle continues: EW yellow then ALLRED, then NS green again. next_dir alternates indefinitely; one-hot heads never both non-red.
- ped_req pulse during NS green at c10 -> walk=1 for 6 cycles (c25-c30), EW green at c31; next all-red without request is 2 cycles with walk=0.
- run=0 during NS yellow at cnt=03 -> OFF next cycle, both red, cnt_en=0; run=1 again -> 2-cycle ALLRED then EW green (next_dir was still EW? no: kept NS, so NS green).
- Inject cnt=8'h1A while in GREEN -> fault=1 and FAULT next cycle. Heads flash 3'b010 for 8 cycles, then 3'b000 for 8, and repeat. run toggles have no effect; only rst recovers to OFF.
- rst asserted mid-walk extended ALLRED -> next cycle OFF, walk=0, ped_pend cleared, next_dir=NS.
